control_unit: RTL and testbench

//  Main decode control for the 5-stage RV32I pipeline; sits in ID and feeds the ID/EX register.

---
 rtl/control_unit_if.sv | 42 ++++
 rtl/control_unit.sv | 91 +++++++++
 tb/tb_control_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Decode-stage control bundle: opcode/flush in, registered ID/EX control fields out.
// The master side drives the opcode and flush; the slave side is the control unit.
interface control_unit_if #(
    parameter int OPCODE_W = 7
);
    logic [OPCODE_W-1:0] instruction6_0;
    logic                flush;
    logic                Branch;
    logic                MemRead;
    logic                MemToReg;
    logic [1:0]          ALUOp;
    logic                MemWrite;
    logic                ALUSrc;
    logic                RegWrite;
    logic                illegal;

    modport master (
        output instruction6_0,
        output flush,
        input  Branch,
        input  MemRead,
        input  MemToReg,
        input  ALUOp,
        input  MemWrite,
        input  ALUSrc,
        input  RegWrite,
        input  illegal
    );

    modport slave (
        input  instruction6_0,
        input  flush,
        output Branch,
        output MemRead,
        output MemToReg,
        output ALUOp,
        output MemWrite,
        output ALUSrc,
        output RegWrite,
        output illegal
    );
endinterface

// File: rtl/control_unit.sv
// RV32I main decode for the ID stage; all control fields are registered so the
// outputs never depend combinationally on the opcode or flush.
module control_unit #(
    parameter int OPCODE_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus
);

    localparam logic [OPCODE_W-1:0] OP_R_TYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I_ALU  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RFUNC = 2'b10;
    localparam logic [1:0] ALU_IFUNC = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    ctrl_t ctrl_next;
    ctrl_t ctrl_reg;

    // A bubble is all zeros, including illegal, so a flushed slot never raises a trap.
    // Opcodes carrying X/Z match no case item and land in the illegal default.
    always_comb begin
        ctrl_next = '0;
        if (!bus.flush) begin
            case (bus.instruction6_0)
                OP_R_TYPE: begin
                    ctrl_next.alu_op    = ALU_RFUNC;
                    ctrl_next.reg_write = 1'b1;
                end
                OP_I_ALU: begin
                    ctrl_next.alu_op    = ALU_IFUNC;
                    ctrl_next.alu_src   = 1'b1;
                    ctrl_next.reg_write = 1'b1;
                end
                OP_LOAD: begin
                    ctrl_next.mem_read   = 1'b1;
                    ctrl_next.mem_to_reg = 1'b1;
                    ctrl_next.alu_op     = ALU_ADD;
                    ctrl_next.alu_src    = 1'b1;
                    ctrl_next.reg_write  = 1'b1;
                end
                OP_STORE: begin
                    ctrl_next.alu_op    = ALU_ADD;
                    ctrl_next.mem_write = 1'b1;
                    ctrl_next.alu_src   = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl_next.branch = 1'b1;
                    ctrl_next.alu_op = ALU_SUB;
                end
                default: begin
                    ctrl_next.illegal = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
        end
    end

    assign bus.Branch   = ctrl_reg.branch;
    assign bus.MemRead  = ctrl_reg.mem_read;
    assign bus.MemToReg = ctrl_reg.mem_to_reg;
    assign bus.ALUOp    = ctrl_reg.alu_op;
    assign bus.MemWrite = ctrl_reg.mem_write;
    assign bus.ALUSrc   = ctrl_reg.alu_src;
    assign bus.RegWrite = ctrl_reg.reg_write;
    assign bus.illegal  = ctrl_reg.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Randomized and directed bench for control_unit, checked against a table-lookup
// model of the decode; each output vector is {Branch,MemRead,MemToReg,ALUOp,MemWrite,ALUSrc,RegWrite,illegal}.
module tb_control_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    control_unit_if #(.OPCODE_W(7)) bus ();

    control_unit #(.OPCODE_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] ref_tab [bit [6:0]];
    logic [6:0] legal_ops [5];

    function automatic logic [8:0] dut_vec();
        return {bus.Branch, bus.MemRead, bus.MemToReg, bus.ALUOp,
                bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.illegal};
    endfunction

    function automatic logic [8:0] model(input logic [6:0] op, input logic fl);
        if (fl) return 9'b0;
        if (ref_tab.exists(op)) return ref_tab[op];
        return 9'b0_0_0_00_0_0_0_1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst_n = 1'b0;
        bus.instruction6_0 = 7'b0110011;
        bus.flush = 1'b0;
        #2;
        obs = dut_vec();
        total++;
        if (obs !== 9'b0) begin
            $display("FAIL reset_no_edge: got %b want %b", obs, 9'b0);
            bad++;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            obs = dut_vec();
            total++;
            if (obs !== 9'b0) begin
                $display("FAIL reset_held%0d: got %b want %b", i, obs, 9'b0);
                bad++;
            end
        end
        rst_n = 1'b1;
        step();
        obs = dut_vec();
        total++;
        if (obs !== model(7'b0110011, 1'b0)) begin
            $display("FAIL reset_release: got %b want %b", obs, model(7'b0110011, 1'b0));
            bad++;
        end
        $display("reset: outputs %b after release", obs);
    endtask

    task automatic test_table();
        logic [8:0] obs;
        logic [8:0] exp;
        for (int i = 0; i < 5; i++) begin
            bus.instruction6_0 = legal_ops[i];
            bus.flush = 1'b0;
            step();
            obs = dut_vec();
            exp = model(legal_ops[i], 1'b0);
            total++;
            if (obs !== exp) begin
                $display("FAIL table_op%b: got %b want %b", legal_ops[i], obs, exp);
                bad++;
            end
            $display("table: op=%b out=%b", legal_ops[i], obs);
        end
    endtask

    task automatic test_illegal();
        logic [8:0] obs;
        logic [6:0] ops [3];
        ops[0] = 7'b1101111;
        ops[1] = 7'b0000000;
        ops[2] = 7'b0110011;
        for (int i = 0; i < 3; i++) begin
            bus.instruction6_0 = ops[i];
            bus.flush = 1'b0;
            step();
            obs = dut_vec();
            total++;
            if (obs !== model(ops[i], 1'b0)) begin
                $display("FAIL illegal_op%b: got %b want %b", ops[i], obs, model(ops[i], 1'b0));
                bad++;
            end
            $display("illegal: op=%b illegal=%b", ops[i], bus.illegal);
        end
    endtask

    task automatic test_flush();
        logic [8:0] obs;
        bus.instruction6_0 = 7'b0000011;
        bus.flush = 1'b1;
        step();
        obs = dut_vec();
        total++;
        if (obs !== 9'b0) begin
            $display("FAIL flush_lw: got %b want %b", obs, 9'b0);
            bad++;
        end
        bus.instruction6_0 = 7'b1111111;
        step();
        obs = dut_vec();
        total++;
        if (obs !== 9'b0) begin
            $display("FAIL flush_illegal_op: got %b want %b", obs, 9'b0);
            bad++;
        end
        bus.instruction6_0 = 7'b0000011;
        bus.flush = 1'b0;
        step();
        obs = dut_vec();
        total++;
        if (obs !== model(7'b0000011, 1'b0)) begin
            $display("FAIL flush_release: got %b want %b", obs, model(7'b0000011, 1'b0));
            bad++;
        end
        $display("flush: lw row after release %b", obs);
    endtask

    task automatic test_async_reset();
        logic [8:0] obs;
        bus.instruction6_0 = 7'b0100011;
        bus.flush = 1'b0;
        step();
        total++;
        if (bus.MemWrite !== 1'b1) begin
            $display("FAIL async_sw_row: got MemWrite=%b want 1", bus.MemWrite);
            bad++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = dut_vec();
        total++;
        if (obs !== 9'b0) begin
            $display("FAIL async_reset_clear: got %b want %b", obs, 9'b0);
            bad++;
        end
        step();
        rst_n = 1'b1;
        step();
        obs = dut_vec();
        total++;
        if (obs !== model(7'b0100011, 1'b0)) begin
            $display("FAIL async_reset_recover: got %b want %b", obs, model(7'b0100011, 1'b0));
            bad++;
        end
        $display("async_reset: MemWrite cleared mid-cycle, recovered %b", obs);
    endtask

    task automatic test_random();
        logic [8:0] obs;
        logic [8:0] exp;
        logic [6:0] op;
        logic       fl;
        int         errs_before;
        errs_before = bad;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(1, 0) == 1) op = legal_ops[$urandom_range(4, 0)];
            else op = 7'($urandom);
            fl = ($urandom_range(7, 0) == 0);
            bus.instruction6_0 = op;
            bus.flush = fl;
            step();
            obs = dut_vec();
            exp = model(op, fl);
            total++;
            if (obs !== exp) begin
                $display("FAIL random%0d op=%b flush=%b: got %b want %b", i, op, fl, obs, exp);
                bad++;
            end
            total++;
            if (bus.MemRead && bus.MemWrite) begin
                $display("FAIL random%0d_rd_wr: got MemRead=1 MemWrite=1 want not both", i);
                bad++;
            end
            total++;
            if ((bus.MemWrite || bus.Branch) && bus.RegWrite) begin
                $display("FAIL random%0d_regwrite: got RegWrite=1 want 0", i);
                bad++;
            end
        end
        $display("random: 1000 cycles, %0d new failures", bad - errs_before);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        legal_ops[0] = 7'b0110011;
        legal_ops[1] = 7'b0010011;
        legal_ops[2] = 7'b0000011;
        legal_ops[3] = 7'b0100011;
        legal_ops[4] = 7'b1100011;
        // Fields: Branch MemRead MemToReg ALUOp MemWrite ALUSrc RegWrite illegal
        ref_tab[7'b0110011] = 9'b0_0_0_10_0_0_1_0;
        ref_tab[7'b0010011] = 9'b0_0_0_11_0_1_1_0;
        ref_tab[7'b0000011] = 9'b0_1_1_00_0_1_1_0;
        ref_tab[7'b0100011] = 9'b0_0_0_00_1_1_0_0;
        ref_tab[7'b1100011] = 9'b1_0_0_01_0_0_0_0;

        test_reset();
        test_table();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
